instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  IF stage of the MIPS core: owns the PC, fetches words from instruction memory and buffers them.
//  It presents {pc, instr} and next_opCode to the decode stage, where main control consumes it.
//  Handles decode back-pressure and branch redirects (beq resolved downstream).
//  Empty buffer drives opcode 6'h00 with if_valid=0; decode treats that as a bubble.
// PARAMETERS
//  ADDR_W     32        PC / imem address width (bits)
//  RESET_PC   32'h0     first fetch address after reset
//  BUF_DEPTH  2         fetch buffer entries (power of 2, >=2)
// PORTS
//  clk            in   1       core clock, all logic on rising edge
//  rst_n          in   1       synchronous reset, active-low
//  imem_req       out  1       fetch request valid
//  imem_addr      out  ADDR_W  fetch address (word aligned, [1:0]=0)
//  imem_gnt       in   1       request accepted this cycle (req&gnt = handshake)
//  imem_rvalid    in   1       read data valid (>=1 cycle after gnt, in order)
//  imem_rdata     in   32      instruction word
//  if_valid       out  1       buffer head valid to decode
//  if_ready       in   1       decode accepts head (if_valid&if_ready = pop)
//  if_instr       out  32      head instruction
//  if_pc          out  ADDR_W  head PC
//  next_opCode    out  6       if_instr[31:26] when if_valid, else 6'h00
//  redirect       in   1       taken branch: flush and refetch from redirect_pc
//  redirect_pc    in   ADDR_W  branch target (bits [1:0] ignored, forced 0)
//  stall_cnt      out  32      decode-stall cycle count (only with IFU_STALL_CNT_EN)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): pc=RESET_PC, buffer empty, state=FETCH, at most one request outstanding = none.
//    Output values under reset: imem_req=0, if_valid=0, next_opCode=0, stall_cnt=0.
//  - FSM states and transitions:
//    FETCH: imem_req=1 iff free slots > outstanding; on req&gnt -> WAIT, pc+=4.
//    WAIT: imem_req=0; on rvalid push {issued_pc, rdata} -> FETCH.
//    DRAIN: redirect arrived while a response was pending. Discard the next rvalid, then -> FETCH.
//  - Only one request is outstanding at a time. A slot is reserved at grant, so a push never overflows.
//  - Latency: reset release -> imem_req=1 next cycle. rvalid -> if_valid next cycle (registered buffer).
//  - Push and pop in the same cycle are legal when full; occupancy is unchanged.
//  - PC arithmetic is modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0 with no error.
//  - Redirect (highest priority, single-cycle pulse):
//    - Buffer is cleared the same edge; if_valid=0 next cycle.
//    - pc <= {redirect_pc[ADDR_W-1:2],2'b00}.
//    - Any pop in that cycle is still honoured by decode, but the buffer is cleared regardless.
//    - If in WAIT without rvalid -> DRAIN.
//    - If rvalid coincides with redirect, the data is dropped -> FETCH.
//    - If a grant coincides with redirect, the granted request is treated as stale -> DRAIN.
//  - imem_req/imem_addr stay stable while req&!gnt, except on redirect, which may retarget the address.
//  - Reset mid-transaction: the state is abandoned; any late rvalid after reset is ignored because state=FETCH.
// CONFIGURATION
//  IFU_STALL_CNT_EN defined:
//    stall_cnt increments (saturating at 2^32-1) each cycle if_valid&!if_ready.
//    Cleared by reset only.
//  IFU_STALL_CNT_EN undefined:
//    stall_cnt port is tied to 32'h0; no counter logic is present.
// STRUCTURE
//  mips_pkg:
//    - opcode constants OP_RTYPE=6'h00, OP_ADDI=6'h08, OP_BEQ=6'h04, OP_LW=6'h23,
//      OP_LH=6'h21, OP_LHU=6'h25, OP_SW=6'h2B;
//    - typedef fetch_entry_t {pc, instr};
//    - enum ifu_state_t {FETCH, WAIT, DRAIN}.
//  Sub-module ifu_fifo:
//    - generic BUF_DEPTH sync FIFO of fetch_entry_t with push/pop/clear, count, full/empty.
//    - Same-cycle push+pop allowed when full.
// TESTING
//  1 Reset held 3 cycles, then released -> cycle+1 imem_req=1, imem_addr=0; if_valid=0, next_opCode=0 throughout.
//  2 imem returns 0x2008_0005, 0x8C09_0004, 0x1109_0002 with gnt=1 and 1-cycle rvalid; if_ready=1.
//    -> if_pc 0,4,8 in order; next_opCode 0x08,0x23,0x04.
//  3 if_ready=0 for 6 cycles -> buffer fills to 2, imem_req drops to 0, no data lost.
//    On release, entries pop in order; stall_cnt=6 with IFU_STALL_CNT_EN.
//  4 Redirect to 0x40 while in WAIT; stale rvalid arrives 2 cycles later.
//    -> stale word is never seen by decode; next fetch addr=0x40; if_valid=0 the cycle after redirect.
//  5 Redirect to 0x103 coincident with rvalid and a pop.
//    -> rvalid data dropped, buffer empty, next imem_addr=0x100.
//  6 RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; if_pc matches.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, fetch buffer entry and IF-stage state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Widest PC a fetch entry can carry; the IF stage zero-extends narrower PCs into it.
  localparam int IFU_ADDR_W = 32;

  typedef struct packed {
    logic [IFU_ADDR_W-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } ifu_state_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO of fetch entries with clear; push and pop may coincide even when full.
module ifu_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             push_data,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests: clear wins, pop needs data, push needs room unless a pop frees it.
  always_comb begin
    do_pop_s  = pop && (count_r != '0) && !clear;
    do_push_s = push && !clear && ((count_r != FULL_CNT) || do_pop_s);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

  // Status and head presentation.
  always_comb begin
    head  = mem_r[rd_ptr_r];
    count = count_r;
    full  = (count_r == FULL_CNT);
    empty = (count_r == '0);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, issues one imem request at a time and buffers words for decode.
// Optional decode-stall counter is built only when IFU_STALL_CNT_EN is defined.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [5:0]        next_opCode,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       stall_cnt
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  ifu_state_t        state_r;
  ifu_state_t        state_nxt_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] issued_pc_r;
  logic              run_r;
  logic              grant_s;
  logic              push_s;
  logic              pop_s;
  logic              buf_full_s;
  logic              buf_empty_s;
  logic [CNT_W-1:0]  buf_count_s;
  logic [CNT_W-1:0]  free_slots_s;
  logic [CNT_W-1:0]  outstanding_s;
  fetch_entry_t      push_entry_s;
  fetch_entry_t      head_s;
  logic              redirect_pc_unused_s;

  ifu_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (push_entry_s),
    .head      (head_s),
    .count     (buf_count_s),
    .full      (buf_full_s),
    .empty     (buf_empty_s)
  );

  // Slot accounting: a request may only go out while a free slot is left beyond any pending one.
  always_comb begin
    free_slots_s         = CNT_W'(BUF_DEPTH) - buf_count_s;
    outstanding_s        = CNT_W'(state_r != FETCH);
    grant_s              = imem_req && imem_gnt;
    pop_s                = if_valid && if_ready;
    redirect_pc_unused_s = ^redirect_pc[1:0];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; a redirect turns any still-pending response into one to discard.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FETCH: begin
        if (grant_s) state_nxt_s = redirect ? DRAIN : WAIT;
        else         state_nxt_s = FETCH;
      end
      WAIT: begin
        if (imem_rvalid)   state_nxt_s = FETCH;
        else if (redirect) state_nxt_s = DRAIN;
        else               state_nxt_s = WAIT;
      end
      DRAIN: begin
        if (imem_rvalid) state_nxt_s = FETCH;
        else             state_nxt_s = DRAIN;
      end
      default: state_nxt_s = FETCH;
    endcase
  end

  // FSM outputs: request issue and buffer push.
  always_comb begin
    imem_req = 1'b0;
    push_s   = 1'b0;
    case (state_r)
      FETCH:   imem_req = run_r && (free_slots_s > outstanding_s);
      WAIT:    push_s   = imem_rvalid && !redirect && (!buf_full_s || pop_s);
      DRAIN:   push_s   = 1'b0;
      default: imem_req = 1'b0;
    endcase
  end

  // Entry captured on a response: PC of the request that produced it.
  always_comb begin
    push_entry_s       = '0;
    push_entry_s.pc    = IFU_ADDR_W'(issued_pc_r);
    push_entry_s.instr = imem_rdata;
  end

  // PC, issued PC and run flag; run_r holds the request off for the cycle reset is seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r        <= RESET_PC;
      issued_pc_r <= RESET_PC;
      run_r       <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (redirect)     pc_r <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (grant_s) pc_r <= pc_r + ADDR_W'(4);
      else              pc_r <= pc_r;
      if (grant_s) issued_pc_r <= pc_r;
    end
  end

  assign imem_addr = pc_r;

  // Decode-facing view of the buffer head; an empty buffer reads as an R-type bubble.
  always_comb begin
    if_valid = !buf_empty_s;
    if_instr = head_s.instr;
    if_pc    = head_s.pc[ADDR_W-1:0];
    if (!buf_empty_s) next_opCode = opcode_of(head_s.instr);
    else              next_opCode = OP_RTYPE;
  end

`ifdef IFU_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles decode holds a valid head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'h0;
    end else if (if_valid && !if_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'h1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule
